// File: rtl/switch_merge.sv
// 2-to-1 merge of the address switch return streams: two drop-on-full input
// FIFOs, a round-robin arbiter and one registered valid/ready output stage.
module switch_merge #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] data_a,
    input  logic              vld_a,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] data_b,
    input  logic              vld_b,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data,
    output logic              vld,
    input  logic              rdy,
    output logic              src,
    output logic              full_a,
    output logic              full_b,
    output logic [CNT_W-1:0]  drop_a,
    output logic [CNT_W-1:0]  drop_b
);

    localparam int BEAT_W = ADDR_W + DATA_W;
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_FW = PTR_W + 1;
    localparam logic [CNT_FW-1:0] DEPTH_C  = CNT_FW'(DEPTH);
    localparam logic [CNT_FW-1:0] CNT_ONE  = CNT_FW'(1);
    localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0]  DROP_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0]  DROP_MAX = {CNT_W{1'b1}};

    // Index 0 is port A, index 1 is port B throughout.
    logic [1:0]        in_vld_s;
    logic [BEAT_W-1:0] in_beat_s [2];

    logic [BEAT_W-1:0] mem_q    [2][DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q [2];
    logic [PTR_W-1:0]  wr_ptr_d [2];
    logic [PTR_W-1:0]  rd_ptr_q [2];
    logic [PTR_W-1:0]  rd_ptr_d [2];
    logic [CNT_FW-1:0] cnt_q    [2];
    logic [CNT_FW-1:0] cnt_d    [2];
    logic [CNT_W-1:0]  drop_q   [2];
    logic [CNT_W-1:0]  drop_d   [2];
    logic [1:0]        full_q, full_d;
    logic              last_gnt_q, last_gnt_d;
    logic              out_vld_q, out_vld_d;
    logic              out_src_q, out_src_d;
    logic [BEAT_W-1:0] out_beat_q, out_beat_d;

    logic              load_s;
    logic [1:0]        ne_s;
    logic              gnt_vld_s;
    logic              gnt_src_s;
    logic [1:0]        pop_s;
    logic [1:0]        push_s;
    logic [BEAT_W-1:0] gnt_beat_s;

    assign in_vld_s     = {vld_b, vld_a};
    assign in_beat_s[0] = {addr_a, data_a};
    assign in_beat_s[1] = {addr_b, data_b};

    // Round-robin grant; only meaningful when the output register can load.
    always_comb begin
        load_s    = !out_vld_q || rdy;
        ne_s      = {cnt_q[1] != '0, cnt_q[0] != '0};
        gnt_vld_s = 1'b0;
        gnt_src_s = 1'b0;
        if (!load_s) begin
            gnt_vld_s = 1'b0;
        end else if (ne_s == 2'b11) begin
            gnt_vld_s = 1'b1;
            gnt_src_s = ~last_gnt_q;
        end else if (ne_s[0]) begin
            gnt_vld_s = 1'b1;
            gnt_src_s = 1'b0;
        end else if (ne_s[1]) begin
            gnt_vld_s = 1'b1;
            gnt_src_s = 1'b1;
        end else begin
            gnt_vld_s = 1'b0;
        end
        if (gnt_vld_s) begin
            pop_s = gnt_src_s ? 2'b10 : 2'b01;
        end else begin
            pop_s = 2'b00;
        end
        gnt_beat_s = mem_q[gnt_src_s][rd_ptr_q[gnt_src_s]];
    end

    // FIFO bookkeeping; a full FIFO still accepts a beat in the cycle it pops.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            push_s[p]   = in_vld_s[p] && ((cnt_q[p] != DEPTH_C) || pop_s[p]);
            wr_ptr_d[p] = push_s[p] ? wr_ptr_q[p] + PTR_ONE : wr_ptr_q[p];
            rd_ptr_d[p] = pop_s[p]  ? rd_ptr_q[p] + PTR_ONE : rd_ptr_q[p];
            case ({push_s[p], pop_s[p]})
                2'b10:   cnt_d[p] = cnt_q[p] + CNT_ONE;
                2'b01:   cnt_d[p] = cnt_q[p] - CNT_ONE;
                default: cnt_d[p] = cnt_q[p];
            endcase
            if (in_vld_s[p] && !push_s[p] && (drop_q[p] != DROP_MAX)) begin
                drop_d[p] = drop_q[p] + DROP_ONE;
            end else begin
                drop_d[p] = drop_q[p];
            end
            full_d[p] = (cnt_d[p] == DEPTH_C);
        end
    end

    // Output register: load on grant, go idle when free with nothing to send.
    always_comb begin
        out_vld_d  = out_vld_q;
        out_src_d  = out_src_q;
        out_beat_d = out_beat_q;
        last_gnt_d = last_gnt_q;
        if (gnt_vld_s) begin
            out_vld_d  = 1'b1;
            out_src_d  = gnt_src_s;
            out_beat_d = gnt_beat_s;
            last_gnt_d = gnt_src_s;
        end else if (load_s) begin
            out_vld_d = 1'b0;
        end else begin
            out_vld_d = out_vld_q;
        end
    end

    // Control state with synchronous reset; last grant starts at B so A wins first.
    always_ff @(posedge clk) begin
        if (rstn) begin
            for (int p = 0; p < 2; p++) begin
                wr_ptr_q[p] <= '0;
                rd_ptr_q[p] <= '0;
                cnt_q[p]    <= '0;
                drop_q[p]   <= '0;
            end
            full_q     <= 2'b00;
            last_gnt_q <= 1'b1;
            out_vld_q  <= 1'b0;
            out_src_q  <= 1'b0;
            out_beat_q <= '0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                wr_ptr_q[p] <= wr_ptr_d[p];
                rd_ptr_q[p] <= rd_ptr_d[p];
                cnt_q[p]    <= cnt_d[p];
                drop_q[p]   <= drop_d[p];
            end
            full_q     <= full_d;
            last_gnt_q <= last_gnt_d;
            out_vld_q  <= out_vld_d;
            out_src_q  <= out_src_d;
            out_beat_q <= out_beat_d;
        end
    end

    // Storage array needs no reset: occupancy counts gate every read.
    always_ff @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
            if (push_s[p]) begin
                mem_q[p][wr_ptr_q[p]] <= in_beat_s[p];
            end
        end
    end

    assign addr   = out_beat_q[BEAT_W-1:DATA_W];
    assign data   = out_beat_q[DATA_W-1:0];
    assign vld    = out_vld_q;
    assign src    = out_src_q;
    assign full_a = full_q[0];
    assign full_b = full_q[1];
    assign drop_a = drop_q[0];
    assign drop_b = drop_q[1];

endmodule

// File: tb/tb_switch_merge.sv
// Self-checking bench for switch_merge: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_switch_merge;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 8;
    localparam int DMAX   = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rstn = 1'b1;
    logic [ADDR_W-1:0] addr_a = '0, addr_b = '0, addr;
    logic [DATA_W-1:0] data_a = '0, data_b = '0, data;
    logic              vld_a = 1'b0, vld_b = 1'b0, vld, rdy = 1'b1, src;
    logic              full_a, full_b;
    logic [CNT_W-1:0]  drop_a, drop_b;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [ADDR_W+DATA_W-1:0] qa[$];
    logic [ADDR_W+DATA_W-1:0] qb[$];
    logic              m_vld = 1'b0;
    logic [ADDR_W-1:0] m_addr = '0;
    logic [DATA_W-1:0] m_data = '0;
    logic              m_src = 1'b0;
    logic              m_lg = 1'b1;
    int                m_drop_a = 0;
    int                m_drop_b = 0;

    always #5 clk = ~clk;

    switch_merge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rstn(rstn),
        .addr_a(addr_a), .data_a(data_a), .vld_a(vld_a),
        .addr_b(addr_b), .data_b(data_b), .vld_b(vld_b),
        .addr(addr), .data(data), .vld(vld), .rdy(rdy), .src(src),
        .full_a(full_a), .full_b(full_b), .drop_a(drop_a), .drop_b(drop_b)
    );

    task automatic model_edge();
        logic load;
        int g, sa, sb;
        logic [ADDR_W+DATA_W-1:0] beat;
        if (rstn) begin
            qa.delete(); qb.delete();
            m_vld = 1'b0; m_addr = '0; m_data = '0; m_src = 1'b0;
            m_lg = 1'b1; m_drop_a = 0; m_drop_b = 0;
        end else begin
            load = !m_vld || rdy;
            g = -1; sa = qa.size(); sb = qb.size();
            if (load) begin
                if (sa > 0 && sb > 0) g = m_lg ? 0 : 1;
                else if (sa > 0) g = 0;
                else if (sb > 0) g = 1;
            end
            if (g == 0) begin
                beat = qa.pop_front();
                {m_addr, m_data} = beat; m_src = 1'b0; m_lg = 1'b0; m_vld = 1'b1;
            end else if (g == 1) begin
                beat = qb.pop_front();
                {m_addr, m_data} = beat; m_src = 1'b1; m_lg = 1'b1; m_vld = 1'b1;
            end else if (load) begin
                m_vld = 1'b0;
            end
            if (vld_a) begin
                if (sa < DEPTH || g == 0) qa.push_back({addr_a, data_a});
                else if (m_drop_a < DMAX) m_drop_a++;
            end
            if (vld_b) begin
                if (sb < DEPTH || g == 1) qb.push_back({addr_b, data_b});
                else if (m_drop_b < DMAX) m_drop_b++;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b1; vld_a = 1'b0; vld_b = 1'b0; rdy = 1'b1;
        step();
        rstn = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b1; rdy = 1'b1;
        step(); step();
        n_cmp++;
        if ({vld, src, full_a, full_b} !== 4'b0000) begin
            n_err++; $display("FAIL reset_flags got %b required 0000", {vld, src, full_a, full_b});
        end
        n_cmp++;
        if ({addr, data} !== 24'h000000) begin
            n_err++; $display("FAIL reset_beat got %h required 000000", {addr, data});
        end
        n_cmp++;
        if ({drop_a, drop_b} !== 16'h0000) begin
            n_err++; $display("FAIL reset_drops got %h required 0000", {drop_a, drop_b});
        end
        rstn = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        vld_a = 1'b1; addr_a = 8'h12; data_a = 16'hBEEF; rdy = 1'b1;
        step();
        vld_a = 1'b0;
        n_cmp++;
        if (vld !== 1'b0) begin
            n_err++; $display("FAIL single_early got vld=%b required 0", vld);
        end
        step();
        n_cmp++;
        if ({vld, addr, data, src} !== {1'b1, 8'h12, 16'hBEEF, 1'b0}) begin
            n_err++; $display("FAIL single_beat got vld=%b addr=%h data=%h src=%b required 1 12 beef 0",
                              vld, addr, data, src);
        end
        step();
        n_cmp++;
        if (vld !== 1'b0) begin
            n_err++; $display("FAIL single_once got vld=%b required 0", vld);
        end
    endtask

    task automatic test_alternate();
        int gd[$];
        int gs[$];
        int exp_d[6] = '{1, 11, 2, 12, 3, 13};
        do_reset();
        for (int c = 0; c < 12; c++) begin
            vld_a = (c < 3); data_a = 16'(c + 1);  addr_a = 8'(c);
            vld_b = (c < 3); data_b = 16'(c + 11); addr_b = 8'(c + 8'h40);
            if (vld && rdy) begin gd.push_back(int'(data)); gs.push_back(int'(src)); end
            step();
        end
        n_cmp++;
        if (gd.size() != 6) begin
            n_err++; $display("FAIL alt_count got %0d beats required 6", gd.size());
        end
        for (int i = 0; i < 6 && i < gd.size(); i++) begin
            n_cmp++;
            if (gd[i] != exp_d[i] || gs[i] != (i % 2)) begin
                n_err++; $display("FAIL alt_order idx %0d got data=%0d src=%0d required data=%0d src=%0d",
                                  i, gd[i], gs[i], exp_d[i], i % 2);
            end
        end
    endtask

    task automatic test_overflow();
        int gd[$];
        do_reset();
        rdy = 1'b0;
        for (int i = 0; i < 6; i++) begin
            vld_a = 1'b1; data_a = 16'(i + 1); addr_a = 8'(i + 8'h20);
            step();
        end
        vld_a = 1'b0;
        n_cmp++;
        if ({full_a, drop_a} !== {1'b1, 8'd1}) begin
            n_err++; $display("FAIL ovf_full_drop got full_a=%b drop_a=%0d required 1 1", full_a, drop_a);
        end
        n_cmp++;
        if ({vld, data} !== {1'b1, 16'd1}) begin
            n_err++; $display("FAIL ovf_hold got vld=%b data=%0d required 1 1", vld, data);
        end
        rdy = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (vld && rdy) gd.push_back(int'(data));
            step();
        end
        n_cmp++;
        if (gd.size() != 5) begin
            n_err++; $display("FAIL ovf_count got %0d beats required 5", gd.size());
        end
        for (int i = 0; i < gd.size() && i < 5; i++) begin
            n_cmp++;
            if (gd[i] != i + 1) begin
                n_err++; $display("FAIL ovf_order idx %0d got %0d required %0d", i, gd[i], i + 1);
            end
        end
    endtask

    task automatic test_full_pop();
        int gd[$];
        int exp_d[5] = '{2, 3, 4, 5, 7};
        do_reset();
        rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            vld_a = 1'b1; data_a = 16'(i + 1);
            step();
        end
        n_cmp++;
        if ({full_a, vld, data} !== {1'b1, 1'b1, 16'd1}) begin
            n_err++; $display("FAIL fp_setup got full_a=%b vld=%b data=%0d required 1 1 1", full_a, vld, data);
        end
        rdy = 1'b1; vld_a = 1'b1; data_a = 16'd7;
        step();
        vld_a = 1'b0;
        n_cmp++;
        if ({drop_a, full_a} !== {8'd0, 1'b1}) begin
            n_err++; $display("FAIL fp_accept got drop_a=%0d full_a=%b required 0 1", drop_a, full_a);
        end
        for (int c = 0; c < 10; c++) begin
            if (vld && rdy) gd.push_back(int'(data));
            step();
        end
        n_cmp++;
        if (gd.size() != 5) begin
            n_err++; $display("FAIL fp_count got %0d beats required 5", gd.size());
        end
        for (int i = 0; i < gd.size() && i < 5; i++) begin
            n_cmp++;
            if (gd[i] != exp_d[i]) begin
                n_err++; $display("FAIL fp_order idx %0d got %0d required %0d", i, gd[i], exp_d[i]);
            end
        end
    endtask

    task automatic test_saturate();
        do_reset();
        rdy = 1'b0;
        for (int i = 1; i <= 305; i++) begin
            vld_b = 1'b1; data_b = 16'(i);
            step();
            // First 5 beats are absorbed (1 in output register, 4 in FIFO)
            if (i == 105 || i == 259 || i == 260) begin
                n_cmp++;
                if (int'(drop_b) != i - 5) begin
                    n_err++; $display("FAIL sat_mid after %0d beats got drop_b=%0d required %0d", i, drop_b, i - 5);
                end
            end
        end
        vld_b = 1'b0;
        n_cmp++;
        if ({drop_b, full_b, drop_a} !== {8'd255, 1'b1, 8'd0}) begin
            n_err++; $display("FAIL sat_end got drop_b=%0d full_b=%b drop_a=%0d required 255 1 0",
                              drop_b, full_b, drop_a);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        rdy = 1'b0;
        for (int i = 0; i < 6; i++) begin
            vld_a = 1'b1; data_a = 16'(i + 100);
            vld_b = (i < 3); data_b = 16'(i + 200);
            step();
        end
        vld_a = 1'b0; vld_b = 1'b0;
        n_cmp++;
        if ({vld, full_a, drop_a} !== {1'b1, 1'b1, 8'd1}) begin
            n_err++; $display("FAIL rm_pre got vld=%b full_a=%b drop_a=%0d required 1 1 1", vld, full_a, drop_a);
        end
        rstn = 1'b1;
        step();
        rstn = 1'b0;
        n_cmp++;
        if ({vld, full_a, full_b, drop_a, drop_b} !== {3'b000, 16'h0000}) begin
            n_err++; $display("FAIL rm_clear got vld=%b full=%b%b drops=%0d/%0d required 0 00 0/0",
                              vld, full_a, full_b, drop_a, drop_b);
        end
        rdy = 1'b1;
        vld_a = 1'b1; addr_a = 8'h05; data_a = 16'h0055;
        vld_b = 1'b1; addr_b = 8'h06; data_b = 16'h0066;
        step();
        vld_a = 1'b0; vld_b = 1'b0;
        step();
        n_cmp++;
        if ({vld, src, data} !== {1'b1, 1'b0, 16'h0055}) begin
            n_err++; $display("FAIL rm_first got vld=%b src=%b data=%h required 1 0 0055", vld, src, data);
        end
        step();
        n_cmp++;
        if ({vld, src, data} !== {1'b1, 1'b1, 16'h0066}) begin
            n_err++; $display("FAIL rm_second got vld=%b src=%b data=%h required 1 1 0066", vld, src, data);
        end
        step();
        n_cmp++;
        if (vld !== 1'b0) begin
            n_err++; $display("FAIL rm_stale got vld=%b required 0", vld);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            rstn   = ($urandom_range(0, 299) == 0);
            vld_a  = ($urandom_range(0, 99) < 60);
            vld_b  = ($urandom_range(0, 99) < 60);
            rdy    = ($urandom_range(0, 99) < 50);
            addr_a = 8'($urandom); data_a = 16'($urandom);
            addr_b = 8'($urandom); data_b = 16'($urandom);
            step();
            rstn = 1'b0;
            n_cmp++;
            if (vld !== m_vld) begin
                n_err++; $display("FAIL rnd_vld cycle %0d got %b required %b", c, vld, m_vld);
            end
            if (m_vld) begin
                n_cmp++;
                if ({addr, data, src} !== {m_addr, m_data, m_src}) begin
                    n_err++; $display("FAIL rnd_beat cycle %0d got %h/%h/%b required %h/%h/%b",
                                      c, addr, data, src, m_addr, m_data, m_src);
                end
            end
            n_cmp++;
            if ({full_a, full_b} !== {qa.size() == DEPTH, qb.size() == DEPTH}) begin
                n_err++; $display("FAIL rnd_full cycle %0d got %b%b required %b%b",
                                  c, full_a, full_b, qa.size() == DEPTH, qb.size() == DEPTH);
            end
            n_cmp++;
            if (int'(drop_a) != m_drop_a || int'(drop_b) != m_drop_b) begin
                n_err++; $display("FAIL rnd_drop cycle %0d got %0d/%0d required %0d/%0d",
                                  c, drop_a, drop_b, m_drop_a, m_drop_b);
            end
        end
        vld_a = 1'b0; vld_b = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_alternate();
        test_overflow();
        test_full_pop();
        test_saturate();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
